narrow_arb_2x64to32: RTL and testbench

NARROW_ARB_2X64TO32 -- requirements
Module: narrow_arb_2x64to32

---
 rtl/narrow_arb_2x64to32.sv | 113 +++++++++++
 tb/tb_narrow_arb_2x64to32.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/narrow_arb_2x64to32.sv
// narrow_arb_2x64to32: two 64-bit requesters arbitrated onto one 32-bit stream, upper half first.
// Define NARROW_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round-robin.
`default_nettype none

module narrow_arb_2x64to32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] a0_data,
    input  logic        a0_last,
    input  logic        a0_valid,
    output logic        a0_ready,
    input  logic [63:0] a1_data,
    input  logic        a1_last,
    input  logic        a1_valid,
    output logic        a1_ready,
    output logic [31:0] b_data,
    output logic        b_id,
    output logic        b_last,
    output logic        b_valid,
    input  logic        b_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HALF  = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_word;
    logic        r_id;
    logic        r_last;
    logic        r_lock;
`ifndef NARROW_ARB_FIXED_PRIO_EN
    logic        r_prio;
`endif

    logic        w_can;
    logic        w_gnt;
    logic        w_acc;
    logic [63:0] w_acc_data;
    logic        w_acc_last;

    // A new word fits when nothing is held, or the last half leaves this cycle.
    assign w_can = rst_n && ((r_state == ST_EMPTY) || ((r_state == ST_HALF) && b_ready));

    always_comb begin
        w_gnt = 1'b0;
        if (r_lock) begin
            w_gnt = r_id;
        end else begin
`ifdef NARROW_ARB_FIXED_PRIO_EN
            w_gnt = !a0_valid && a1_valid;
`else
            if (r_prio == 1'b0) begin
                w_gnt = !a0_valid && a1_valid;
            end else begin
                w_gnt = a1_valid || !a0_valid;
            end
`endif
        end
    end

    assign a0_ready   = w_can && !w_gnt;
    assign a1_ready   = w_can && w_gnt;
    assign w_acc      = w_gnt ? (a1_valid && a1_ready) : (a0_valid && a0_ready);
    assign w_acc_data = w_gnt ? a1_data : a0_data;
    assign w_acc_last = w_gnt ? a1_last : a0_last;

    assign b_valid = (r_state != ST_EMPTY);
    assign b_data  = (r_state == ST_FULL) ? r_word[63:32] : r_word[31:0];
    assign b_last  = (r_state == ST_HALF) && r_last;
    assign b_id    = r_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_id    <= 1'b0;
            r_last  <= 1'b0;
            r_lock  <= 1'b0;
`ifndef NARROW_ARB_FIXED_PRIO_EN
            r_prio  <= 1'b0;
`endif
        end else begin
            if (w_acc) begin
                r_id   <= w_gnt;
                r_last <= w_acc_last;
                r_lock <= !w_acc_last;
`ifndef NARROW_ARB_FIXED_PRIO_EN
                if (w_acc_last) begin
                    r_prio <= !w_gnt;
                end
`endif
            end
            case (r_state)
                ST_EMPTY: if (w_acc) r_state <= ST_FULL;
                ST_FULL:  if (b_ready) r_state <= ST_HALF;
                ST_HALF:  if (b_ready) r_state <= w_acc ? ST_FULL : ST_EMPTY;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    // Payload register needs no reset; it is only observed while b_valid is high.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_word <= w_acc_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_narrow_arb_2x64to32.sv
// tb_narrow_arb_2x64to32: random and directed stimulus against a queue-based transfer model.
`default_nettype none

module tb_narrow_arb_2x64to32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] a0_data = '0, a1_data = '0;
    logic        a0_last = 1'b0, a1_last = 1'b0;
    logic        a0_valid = 1'b0, a1_valid = 1'b0;
    logic        a0_ready, a1_ready;
    logic [31:0] b_data;
    logic        b_id, b_last, b_valid;
    logic        b_ready = 1'b0;

    narrow_arb_2x64to32 dut (
        .clk(clk), .rst_n(rst_n),
        .a0_data(a0_data), .a0_last(a0_last), .a0_valid(a0_valid), .a0_ready(a0_ready),
        .a1_data(a1_data), .a1_last(a1_last), .a1_valid(a1_valid), .a1_ready(a1_ready),
        .b_data(b_data), .b_id(b_id), .b_last(b_last), .b_valid(b_valid), .b_ready(b_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        id;
        logic        last;
    } half_t;

    half_t       q[$];
    int          n_total = 0;
    int          n_bad = 0;

    // Stimulus state per requester
    logic        v[2];
    logic [63:0] d[2];
    logic        l[2];
    int          rem[2];
    logic        acc[2];
    logic        br;

    // Model state
    logic        m_lock;
    logic        m_owner;
    logic        m_prio;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen(input int r, input int maxlen);
        if (rem[r] == 0) rem[r] = $urandom_range(1, maxlen);
        d[r] = {$urandom, $urandom};
        l[r] = (rem[r] == 1);
        rem[r]--;
    endtask

    task automatic cycle();
        logic can;
        logic eg;
        logic g;
        @(negedge clk);
        a0_valid = v[0]; a0_data = d[0]; a0_last = l[0];
        a1_valid = v[1]; a1_data = d[1]; a1_last = l[1];
        b_ready  = br;
        #1;
        can = (q.size() == 0) || (q.size() == 1 && br);
        if (m_lock)            eg = m_owner;
        else if (v[0] && v[1]) eg = m_prio;
        else if (v[0])         eg = 1'b0;
        else if (v[1])         eg = 1'b1;
        else                   eg = m_prio;
        chk("a0_ready", {63'd0, a0_ready}, {63'd0, can && !eg});
        chk("a1_ready", {63'd0, a1_ready}, {63'd0, can && eg});
        chk("b_valid", {63'd0, b_valid}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("b_data", {32'd0, b_data}, {32'd0, q[0].d});
            chk("b_id", {63'd0, b_id}, {63'd0, q[0].id});
            chk("b_last", {63'd0, b_last}, {63'd0, q[0].last});
        end
        acc[0] = v[0] && can && !eg;
        acc[1] = v[1] && can && eg;
        if (q.size() != 0 && br) void'(q.pop_front());
        if (acc[0] || acc[1]) begin
            g = acc[1];
            q.push_back('{d: d[g][63:32], id: g, last: 1'b0});
            q.push_back('{d: d[g][31:0],  id: g, last: l[g]});
            if (l[g]) begin
                m_lock = 1'b0;
`ifndef NARROW_ARB_FIXED_PRIO_EN
                m_prio = !g;
`endif
            end else begin
                m_lock  = 1'b1;
                m_owner = g;
            end
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_lock = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
        for (int r = 0; r < 2; r++) begin
            acc[r] = 1'b0; rem[r] = 0; v[r] = 1'b0;
        end
    endtask

    // Reset asserted mid-cycle; outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
        chk("rst_b_last", {63'd0, b_last}, 64'd0);
        chk("rst_b_id", {63'd0, b_id}, 64'd0);
        chk("rst_a0_ready", {63'd0, a0_ready}, 64'd0);
        chk("rst_a1_ready", {63'd0, a1_ready}, 64'd0);
        model_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run(input int n, input int pv, input int pr, input int maxlen);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) v[r] = 1'b0;
                if (!v[r] && $urandom_range(1, 100) <= pv) begin
                    gen(r, maxlen);
                    v[r] = 1'b1;
                end
            end
            br = ($urandom_range(1, 100) <= pr);
            cycle();
        end
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            d[r] = '0; l[r] = 1'b0;
        end
        br = 1'b0;
        model_clear();
        do_reset();

        // Single-word packet: upper then lower half, b_last on the second half only
        v[0] = 1'b1; d[0] = 64'h11112222_33334444; l[0] = 1'b1; br = 1'b1;
        cycle();
        v[0] = 1'b0;
        cycle();
        chk("first_half", {32'd0, b_data}, 64'h11112222);
        cycle();
        chk("second_half", {32'd0, b_data}, 64'h33334444);
        chk("second_last", {63'd0, b_last}, 64'd1);
        cycle();

        // Stall in FULL for 5 cycles with both requesters pending
        do_reset();
        v[0] = 1'b1; d[0] = 64'hA5A5A5A5_5A5A5A5A; l[0] = 1'b1; br = 1'b0;
        cycle();
        v[0] = 1'b1; d[0] = 64'h0123_4567_89AB_CDEF; v[1] = 1'b1; d[1] = 64'hFEED; l[1] = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("stall_data", {32'd0, b_data}, 64'hA5A5A5A5);
        br = 1'b1;
        run(10, 100, 100, 1);

        // Reset while in HALF of a locked packet, then a lone a1 must be granted
        do_reset();
        v[0] = 1'b1; d[0] = {$urandom, $urandom}; l[0] = 1'b0; br = 1'b1;
        cycle();
        v[0] = 1'b0;
        cycle();
        do_reset();
        v[1] = 1'b1; d[1] = {$urandom, $urandom}; l[1] = 1'b1; br = 1'b1;
        cycle();
        chk("post_rst_a1_ready", {63'd0, a1_ready}, 64'd1);
        cycle();

        // Both always valid, single-word packets: grant pattern
        do_reset();
        run(40, 100, 100, 1);
        // Multi-word packets with gaps and back-pressure
        run(3000, 60, 70, 4);
        do_reset();
        run(2000, 90, 90, 3);
        run(1000, 30, 40, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
